// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the 8-bit ALU datapath and the alu_seq command
//   sequencer: ALU S-codes, command opcodes, sequencer FSM states and a
//   small helper used to split multi-position shifts into ALU passes.
package alu_pkg;

  // ALU S-codes. Shift/rotate codes are bases: OR the amount into [1:0].
  localparam logic [4:0] S_SHL  = 5'b00000;
  localparam logic [4:0] S_SHR  = 5'b00100;
  localparam logic [4:0] S_ROL  = 5'b01000;
  localparam logic [4:0] S_ROR  = 5'b01100;
  localparam logic [4:0] S_ZERO = 5'b10000;
  localparam logic [4:0] S_PASS = 5'b11000;
  localparam logic [4:0] S_ADD  = 5'b11001;
  localparam logic [4:0] S_SUB  = 5'b11010;
  localparam logic [4:0] S_NEG  = 5'b11011;
  localparam logic [4:0] S_OR   = 5'b11100;
  localparam logic [4:0] S_AND  = 5'b11101;
  localparam logic [4:0] S_XOR  = 5'b11110;
  localparam logic [4:0] S_NOT  = 5'b11111;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_NEG   = 4'd3,
    OP_OR    = 4'd4,
    OP_AND   = 4'd5,
    OP_XOR   = 4'd6,
    OP_NOT   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_ROL   = 4'd10,
    OP_ROR   = 4'd11,
    OP_MUL   = 4'd12,
    OP_CLR   = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_MUL_ADD = 2'd2,
    ST_MUL_SHF = 2'd3
  } state_e;

  // Positions moved by one ALU pass: the ALU shifts at most 3 per pass.
  function automatic logic [1:0] pass_amt(input logic [2:0] rem);
    return (rem > 3'd3) ? 2'd3 : rem[1:0];
  endfunction

endpackage

// File: rtl/alu.sv
// alu
//   8-bit combinational ALU datapath.
//   Ports:
//     a, b  in  8 - operands
//     s     in  5 - S-code (0xxxx shift/rotate by s[1:0], 10xxx zero,
//                   11xxx PASS/ADD/SUB/NEG/OR/AND/XOR/NOT)
//     f     out 8 - result
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [4:0] s,
  output logic [7:0] f
);

  logic [15:0] rol_full;
  logic [15:0] ror_full;

  // Rotates taken from a doubled copy of a so that amount 0 needs no special case.
  assign rol_full = {a, a} << s[1:0];
  assign ror_full = {a, a} >> s[1:0];

  always_comb begin
    f = 8'h00;
    if (!s[4]) begin
      case (s[3:2])
        2'b00:   f = a << s[1:0];
        2'b01:   f = a >> s[1:0];
        2'b10:   f = rol_full[15:8];
        default: f = ror_full[7:0];
      endcase
    end else if (s[3]) begin
      case (s[2:0])
        3'd0:    f = a;
        3'd1:    f = a + b;
        3'd2:    f = a - b;
        3'd3:    f = 8'h00 - a;
        3'd4:    f = a | b;
        3'd5:    f = a & b;
        3'd6:    f = a ^ b;
        default: f = ~a;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq
//   Accumulator command sequencer around the alu datapath. Accepts one
//   command per valid/ready handshake and runs it as one or more ALU passes
//   (multi-pass shifts/rotates, 8-iteration shift-add multiply).
//   Ports:
//     clk        in  1 - clock
//     rst_n      in  1 - synchronous active-low reset
//     cmd_valid  in  1 - command present
//     cmd_ready  out 1 - accepting (IDLE and not in reset)
//     cmd_op     in  4 - opcode (cmd_op_e)
//     cmd_data   in  8 - operand B / shift amount in [2:0]
//     acc        out 8 - accumulator
//     zero       out 1 - acc == 0
//     done       out 1 - one-cycle completion pulse
//     err        out 1 - reserved opcode, pulses with done
module alu_seq
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] acc,
  output logic       zero,
  output logic       done,
  output logic       err
);

  state_e     state_reg, state_next;
  cmd_op_e    op_reg, op_next;
  logic [7:0] data_reg, data_next;
  logic [2:0] rem_reg, rem_next;
  logic [7:0] acc_reg, acc_next;
  logic [7:0] m_reg, m_next;
  logic [7:0] q_reg, q_next;
  logic [7:0] p_reg, p_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  logic [7:0] alu_a, alu_b, alu_f;
  logic [4:0] alu_s;
  logic [1:0] amt;

  alu u_alu (
    .a (alu_a),
    .b (alu_b),
    .s (alu_s),
    .f (alu_f)
  );

  assign cmd_ready = rst_n && (state_reg == ST_IDLE);
  assign acc       = acc_reg;
  assign zero      = (acc_reg == 8'h00);
  assign done      = done_reg;
  assign err       = err_reg;

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    rem_next   = rem_reg;
    acc_next   = acc_reg;
    m_next     = m_reg;
    q_next     = q_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    alu_a      = acc_reg;
    alu_b      = data_reg;
    alu_s      = S_PASS;
    amt        = pass_amt(rem_reg);

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_next   = cmd_op_e'(cmd_op);
          data_next = cmd_data;
          rem_next  = cmd_data[2:0];
          if (cmd_op_e'(cmd_op) == OP_MUL) begin
            m_next     = acc_reg;
            q_next     = cmd_data;
            p_next     = 8'h00;
            cnt_next   = 3'd0;
            state_next = ST_MUL_ADD;
          end else begin
            state_next = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        // Single-pass ops fall through to completion; shifts loop here
        // until the remaining amount reaches zero.
        state_next = ST_IDLE;
        done_next  = 1'b1;
        acc_next   = alu_f;
        case (op_reg)
          OP_LOAD: begin
            alu_a = data_reg;
            alu_s = S_PASS;
          end
          OP_ADD:  alu_s = S_ADD;
          OP_SUB:  alu_s = S_SUB;
          OP_NEG:  alu_s = S_NEG;
          OP_OR:   alu_s = S_OR;
          OP_AND:  alu_s = S_AND;
          OP_XOR:  alu_s = S_XOR;
          OP_NOT:  alu_s = S_NOT;
          OP_CLR:  alu_s = S_ZERO;
          OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
            // Opcode low bits line up with the S-code shift-type field.
            alu_s    = {1'b0, op_reg[1:0], amt};
            rem_next = rem_reg - {1'b0, amt};
            if (rem_next != 3'd0) begin
              state_next = ST_EXEC;
              done_next  = 1'b0;
            end
          end
          default: begin
            acc_next = acc_reg;
            err_next = 1'b1;
          end
        endcase
      end

      ST_MUL_ADD: begin
        alu_a      = p_reg;
        alu_b      = m_reg;
        alu_s      = q_reg[0] ? S_ADD : S_PASS;
        p_next     = alu_f;
        state_next = ST_MUL_SHF;
      end

      default: begin // ST_MUL_SHF
        alu_a    = m_reg;
        alu_s    = S_SHL | 5'd1;
        m_next   = alu_f;
        q_next   = q_reg >> 1;
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          acc_next   = p_reg;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_MUL_ADD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      op_reg    <= OP_LOAD;
      data_reg  <= 8'h00;
      rem_reg   <= 3'd0;
      acc_reg   <= 8'h00;
      m_reg     <= 8'h00;
      q_reg     <= 8'h00;
      p_reg     <= 8'h00;
      cnt_reg   <= 3'd0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      rem_reg   <= rem_next;
      acc_reg   <= acc_next;
      m_reg     <= m_next;
      q_reg     <= q_next;
      p_reg     <= p_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

endmodule
